// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: I2C master for one register write (START, dev+W, reg, data, STOP).
// Define I2C_MASTER_CLOCK_STRETCH_EN to let a slave stretch SCL in the high phase.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [1:0] nack_stage,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, STOP
  } state_t;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t        state, state_n, cur;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    ph, ph_n;
  logic [2:0]    bitn, bitn_n;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q, dat_q, cur_byte;
  logic          pend, hit, fin;
  logic [1:0]    pend_stage, hit_stage;
  logic          accept, run, tick, last, stall;

  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign run       = (state != IDLE) || accept;
  // the accept cycle is the first clk of START phase S0
  assign cur       = (state == IDLE) ? START : state;
  assign tick      = (cnt == CW'(CLK_DIV - 1));
  assign last      = (cur == START) ? ph[0] : (ph == 2'd3);

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
  assign stall = (ph == 2'd2) && !scl_in &&
                 (state inside {ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, STOP});
`else
  logic unused_scl;
  assign stall      = 1'b0;
  assign unused_scl = scl_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ph         <= 2'd0;
      bitn       <= 3'd7;
      dev_q      <= '0;
      reg_q      <= '0;
      dat_q      <= '0;
      pend       <= 1'b0;
      pend_stage <= 2'd0;
      done       <= 1'b0;
      nack       <= 1'b0;
      nack_stage <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ph    <= ph_n;
      bitn  <= bitn_n;
      done  <= fin;
      if (accept) begin
        dev_q <= cmd_dev_addr;
        reg_q <= cmd_reg_addr;
        dat_q <= cmd_data;
        pend  <= 1'b0;
      end
      if (hit) begin
        pend       <= 1'b1;
        pend_stage <= hit_stage;
      end
      if (fin) begin
        nack       <= pend;
        nack_stage <= pend_stage;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ph_n      = ph;
    bitn_n    = bitn;
    fin       = 1'b0;
    hit       = 1'b0;
    hit_stage = 2'd0;
    if (run && !stall) begin
      state_n = cur;
      if (!tick) begin
        cnt_n = cnt + CW'(1);
      end else begin
        cnt_n = '0;
        ph_n  = ph + 2'd1;
        if (last) begin
          ph_n = 2'd0;
          unique case (cur)
            START: state_n = ADDR;
            ADDR, REG, DATA: begin
              // bitn wraps 0 -> 7, ready for the next byte
              bitn_n = bitn - 3'd1;
              if (bitn == 3'd0) begin
                state_n = (cur == ADDR) ? ACK_A :
                          (cur == REG)  ? ACK_R : ACK_D;
              end
            end
            ACK_A: begin
              state_n = sda_in ? STOP : REG;
              hit     = sda_in;
            end
            ACK_R: begin
              state_n   = sda_in ? STOP : DATA;
              hit       = sda_in;
              hit_stage = 2'd1;
            end
            ACK_D: begin
              state_n   = STOP;
              hit       = sda_in;
              hit_stage = 2'd2;
            end
            STOP: begin
              state_n = IDLE;
              fin     = 1'b1;
            end
            default: state_n = IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    unique case (1'b1)
      state == ADDR: cur_byte = {dev_q, 1'b0};
      state == REG:  cur_byte = reg_q;
      default:       cur_byte = dat_q;
    endcase
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state)
      START: sda_oe = ph[0];
      ADDR, REG, DATA: begin
        scl_oe = !ph[1];
        sda_oe = !cur_byte[bitn];
      end
      ACK_A, ACK_R, ACK_D: scl_oe = !ph[1];
      STOP: begin
        scl_oe = !ph[1];
        sda_oe = (ph != 2'd3);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: bench for i2c_master_ctrl with a behavioural slave at 0x1A.
module tb_i2c_master_ctrl;
  localparam int         CLK_DIV  = 4;
  localparam int         FULL     = 114 * CLK_DIV;
  localparam int         TMO      = 2000;
  localparam logic [6:0] SLV_ADDR = 7'h1A;

  typedef struct {
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] dat;
    int         nb;
    bit         enack;
    int         estage;
    int         elat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, busy, done, nack, scl_oe, sda_oe;
  logic [6:0] cmd_dev_addr = '0;
  logic [7:0] cmd_reg_addr = '0;
  logic [7:0] cmd_data = '0;
  logic [1:0] nack_stage;
  logic       scl_in, sda_in;

  logic slv_sda_low = 1'b0;
  logic slv_scl_low = 1'b0;
  logic force_sda   = 1'b0;
  logic scl_line, sda_line;

  assign scl_line = !scl_oe && !slv_scl_low;
  assign sda_line = !sda_oe && !slv_sda_low && !force_sda;
  assign scl_in   = scl_line;
  assign sda_in   = sda_line;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_data(cmd_data), .busy(busy), .done(done),
    .nack(nack), .nack_stage(nack_stage),
    .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_in(scl_in), .sda_in(sda_in)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural slave / bus monitor, sampled mid-cycle
  int         bitcnt = 0, byte_idx = 0, wr_count = 0, stops = 0;
  int         done_cnt = 0, slv_nack_byte = 0;
  logic [7:0] shreg = '0, reg_lat = '0, slv_reg = '0, slv_data = '0;
  logic       addressed = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic [7:0] mon_bytes[$];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (scl_p && scl_line && sda_p && !sda_line) begin
      bitcnt = 0;
      byte_idx = 0;
      addressed = 1'b0;
      slv_sda_low = 1'b0;
    end else if (scl_p && scl_line && !sda_p && sda_line) begin
      stops++;
    end else if (!scl_p && scl_line) begin
      if (bitcnt < 8) shreg = {shreg[6:0], sda_line};
      bitcnt++;
      if (bitcnt == 9) begin
        mon_bytes.push_back(shreg);
        if (byte_idx == 1) reg_lat = shreg;
        if (byte_idx == 2 && !sda_line) begin
          wr_count++;
          slv_reg = reg_lat;
          slv_data = shreg;
        end
        byte_idx++;
        bitcnt = 0;
      end
    end else if (scl_p && !scl_line) begin
      slv_sda_low = 1'b0;
      if (bitcnt == 8) begin
        if (byte_idx == 0) begin
          addressed = (shreg == {SLV_ADDR, 1'b0});
          slv_sda_low = addressed;
        end else if (byte_idx < 3) begin
          slv_sda_low = addressed && (slv_nack_byte != byte_idx);
        end
      end
    end
    scl_p = scl_line;
    sda_p = sda_line;
  end

  // Reference: first NACKed byte ends the write; each byte is 9 bits of 4 phases
  function automatic vec_t ref_model(logic [6:0] d, logic [7:0] r,
                                     logic [7:0] v, int nb);
    vec_t e;
    int   k;
    k = (d != SLV_ADDR) ? 0 : ((nb == 0) ? 3 : nb);
    e.dev    = d;
    e.rg     = r;
    e.dat    = v;
    e.nb     = nb;
    e.enack  = (k < 3);
    e.estage = (k < 3) ? k : 0;
    e.elat   = CLK_DIV * (2 + 36 * ((k < 3) ? k + 1 : 3) + 4);
    return e;
  endfunction

  task automatic run_cmd(input vec_t v, input string nm);
    int         n, wr0, st0, dc0, nbytes;
    bit         got;
    logic [7:0] exp_b[3];
    exp_b[0] = {v.dev, 1'b0};
    exp_b[1] = v.rg;
    exp_b[2] = v.dat;
    nbytes = v.enack ? v.estage + 1 : 3;
    slv_nack_byte = v.nb;
    @(negedge clk);
    mon_bytes.delete();
    wr0 = wr_count;
    st0 = stops;
    dc0 = done_cnt;
    chk({nm, " ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_dev_addr = v.dev;
    cmd_reg_addr = v.rg;
    cmd_data = v.dat;
    n = 0;
    got = 0;
    while (!got && n < TMO) begin
      @(negedge clk);
      n++;
      if (done) begin
        got = 1;
      end else begin
        cmd_dev_addr = 7'($urandom);
        cmd_reg_addr = 8'($urandom);
        cmd_data = 8'($urandom);
        cmd_valid = (n == 50);
      end
    end
    cmd_valid = 1'b0;
    chk({nm, " latency"}, n, v.elat);
    chk({nm, " nack"}, nack, int'(v.enack));
    if (v.enack) chk({nm, " stage"}, nack_stage, v.estage);
    chk({nm, " bus idle"}, int'(scl_line && sda_line), 1);
    chk({nm, " stop"}, stops - st0, 1);
    chk({nm, " nbytes"}, mon_bytes.size(), nbytes);
    for (int i = 0; i < nbytes && i < mon_bytes.size(); i++)
      chk({nm, " byte"}, mon_bytes[i], exp_b[i]);
    chk({nm, " writes"}, wr_count - wr0, int'(!v.enack));
    if (!v.enack) begin
      chk({nm, " slv reg"}, slv_reg, v.rg);
      chk({nm, " slv data"}, slv_data, v.dat);
    end
    repeat (4) @(negedge clk);
    chk({nm, " one done"}, done_cnt - dc0, 1);
  endtask

  vec_t tbl[6];
  vec_t rv;
  int   n, dc0, wr0;
  bit   got;

  initial begin
    tbl[0] = '{7'h1A, 8'h75, 8'h74, 0, 1'b0, 0, 114 * CLK_DIV};
    tbl[1] = '{7'h1B, 8'h75, 8'h74, 0, 1'b1, 0, 42 * CLK_DIV};
    tbl[2] = '{7'h1A, 8'h10, 8'hA5, 1, 1'b1, 1, 78 * CLK_DIV};
    tbl[3] = '{7'h1A, 8'hFF, 8'h00, 2, 1'b1, 2, 114 * CLK_DIV};
    tbl[4] = '{7'h00, 8'h00, 8'h00, 0, 1'b1, 0, 42 * CLK_DIV};
    tbl[5] = '{7'h1A, 8'h00, 8'hFF, 0, 1'b0, 0, 114 * CLK_DIV};

    repeat (3) @(negedge clk);
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst nack", nack, 0);
    chk("rst stage", nack_stage, 0);
    chk("rst scl_oe", scl_oe, 0);
    chk("rst sda_oe", sda_oe, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_cmd(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 16; i++) begin
      rv = ref_model($urandom_range(0, 1) ? SLV_ADDR : 7'($urandom),
                     8'($urandom), 8'($urandom), $urandom_range(0, 2));
      run_cmd(rv, $sformatf("rnd%0d", i));
    end

    // reset in the middle of a write
    @(negedge clk);
    dc0 = done_cnt;
    slv_nack_byte = 0;
    cmd_dev_addr = 7'h1A;
    cmd_reg_addr = 8'h75;
    cmd_data = 8'h74;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst scl_oe", scl_oe, 0);
    chk("mrst sda_oe", sda_oe, 0);
    chk("mrst busy", busy, 0);
    chk("mrst ready", cmd_ready, 1);
    chk("mrst done", done, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mrst no done", done_cnt - dc0, 0);
    run_cmd(tbl[0], "after rst");

    // back-to-back with cmd_valid held
    @(negedge clk);
    dc0 = done_cnt;
    wr0 = wr_count;
    cmd_dev_addr = 7'h1A;
    cmd_reg_addr = 8'h21;
    cmd_data = 8'h43;
    cmd_valid = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < TMO) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
    end
    chk("b2b lat1", n, FULL);
    chk("b2b ready at done", cmd_ready, 1);
    chk("b2b data1", slv_data, 8'h43);
    cmd_reg_addr = 8'h65;
    cmd_data = 8'h87;
    n = 0;
    got = 0;
    while (!got && n < TMO) begin
      @(negedge clk);
      n++;
      if (n == 1) cmd_valid = 1'b0;
      if (done) got = 1;
    end
    chk("b2b lat2", n, FULL);
    chk("b2b writes", wr_count - wr0, 2);
    chk("b2b reg2", slv_reg, 8'h65);
    chk("b2b data2", slv_data, 8'h87);
    repeat (4) @(negedge clk);
    chk("b2b dones", done_cnt - dc0, 2);

    // slave holds SCL low for 20 cycles in register bit 3 P2
    force_sda = 1'b1;
    @(negedge clk);
    cmd_dev_addr = 7'h1A;
    cmd_reg_addr = 8'h75;
    cmd_data = 8'h74;
    cmd_valid = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < TMO) begin
      @(negedge clk);
      n++;
      if (n == 1) cmd_valid = 1'b0;
      if (n == 52 * CLK_DIV) slv_scl_low = 1'b1;
      if (n == 52 * CLK_DIV + 20) slv_scl_low = 1'b0;
      if (done) got = 1;
    end
`ifdef I2C_MASTER_CLOCK_STRETCH_EN
    chk("stretch latency", n, FULL + 20);
`else
    chk("stretch latency", n, FULL);
`endif
    chk("stretch nack", nack, 0);
    slv_scl_low = 1'b0;
    force_sda = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
